// File: rtl/insn_encoder_pkg.sv
// Shared opcode bases, command codes, state encoding and helpers for the
// A64 instruction encoder.
package insn_encoder_pkg;

  typedef enum logic [2:0] {
    OP_MOVI = 3'd0,
    OP_ADDI = 3'd1,
    OP_SUBI = 3'd2,
    OP_CMP  = 3'd3,
    OP_CBZ  = 3'd4
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  localparam logic [31:0] MOVZ_BASE = 32'hD280_0000;
  localparam logic [31:0] MOVK_BASE = 32'hF280_0000;
  localparam logic [31:0] ADDI_BASE = 32'h9100_0000;
  localparam logic [31:0] SUBI_BASE = 32'hD100_0000;
  localparam logic [31:0] CMP_BASE  = 32'hEB00_0000;
  localparam logic [31:0] CBZ_BASE  = 32'hB400_0000;
  localparam logic [4:0]  XZR       = 5'd31;

  typedef struct packed {
    logic       found;
    logic [1:0] hw;
  } chunk_sel_t;

  // Lowest nonzero 16-bit chunk strictly above cur; chunk 0 is always the MOVZ.
  function automatic chunk_sel_t next_chunk(input logic [63:0] imm, input logic [1:0] cur);
    chunk_sel_t sel;
    sel = '0;
    for (int h = 3; h >= 1; h--) begin
      if (h > int'(cur) && imm[h*16 +: 16] != 16'd0) begin
        sel.found = 1'b1;
        sel.hw    = 2'(h);
      end
    end
    return sel;
  endfunction

  function automatic logic cmd_legal(input logic [2:0] op, input logic [63:0] imm);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_MOVI, OP_CMP:   ok = 1'b1;
      OP_ADDI, OP_SUBI:  ok = (imm < 64'd4096) ||
                              (imm[11:0] == 12'd0 && imm < 64'h100_0000);
      OP_CBZ:            ok = (&imm[63:18]) || (~|imm[63:18]);
      default:           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/a64_field_pack.sv
// Combinational packing of registered command fields into one A64 word.
module a64_field_pack
  import insn_encoder_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  hw,
  input  logic [15:0] chunk,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [23:0] imm,
  output logic [31:0] word
);

  logic        sh;
  logic [11:0] imm12;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    word  = '0;
    sh    = |imm[23:12];
    imm12 = sh ? imm[23:12] : imm[11:0];
    case (op)
      OP_MOVI: word = ((hw == 2'd0) ? MOVZ_BASE : MOVK_BASE) | {9'b0, hw, chunk, rd};
      OP_ADDI: word = ADDI_BASE | {9'b0, sh, imm12, rn, rd};
      OP_SUBI: word = SUBI_BASE | {9'b0, sh, imm12, rn, rd};
      OP_CMP:  word = CMP_BASE  | {11'b0, rm, 6'b0, rn, XZR};
      OP_CBZ:  word = CBZ_BASE  | {8'b0, imm[18:0], rd};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/insn_encoder.sv
// Command-to-A64 encoder: accepts one command at a time and streams its
// instruction words over a valid/ready port, counting transferred words.
module insn_encoder
  import insn_encoder_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [4:0]         cmd_rd,
  input  logic [4:0]         cmd_rn,
  input  logic [4:0]         cmd_rm,
  input  logic [63:0]        cmd_imm,
  output logic               insn_valid,
  input  logic               insn_ready,
  output logic [31:0]        insn_data,
  output logic               insn_last,
  output logic               err,
  output logic [COUNT_W-1:0] insn_count
);

  state_e      state;
  op_e         op_q;
  logic [4:0]  rd_q, rn_q, rm_q;
  logic [63:0] imm_q;
  logic [1:0]  hw_q;
  logic [15:0] chunk;
  logic [31:0] word;
  chunk_sel_t  first_sel, next_sel, after_sel;

  assign cmd_ready = (state == ST_IDLE);
  assign chunk     = imm_q[{hw_q, 4'b0} +: 16];

  // Lookahead so insn_last is known when each MOVI word is presented.
  assign first_sel = next_chunk(cmd_imm, 2'd0);
  assign next_sel  = next_chunk(imm_q, hw_q);
  assign after_sel = next_chunk(imm_q, next_sel.hw);

  a64_field_pack u_pack (
    .op    (op_q),
    .hw    (hw_q),
    .chunk (chunk),
    .rd    (rd_q),
    .rn    (rn_q),
    .rm    (rm_q),
    .imm   (imm_q[23:0]),
    .word  (word)
  );

  assign insn_data = insn_valid ? word : 32'd0;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= OP_MOVI;
      rd_q       <= '0;
      rn_q       <= '0;
      rm_q       <= '0;
      imm_q      <= '0;
      hw_q       <= '0;
      insn_valid <= 1'b0;
      insn_last  <= 1'b0;
      err        <= 1'b0;
      insn_count <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q  <= op_e'(cmd_op);
            rd_q  <= cmd_rd;
            rn_q  <= cmd_rn;
            rm_q  <= cmd_rm;
            imm_q <= cmd_imm;
            hw_q  <= 2'd0;
            if (cmd_legal(cmd_op, cmd_imm)) begin
              state      <= ST_EMIT;
              insn_valid <= 1'b1;
              insn_last  <= (cmd_op == OP_MOVI) ? !first_sel.found : 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (insn_ready) begin
            insn_count <= insn_count + COUNT_W'(1);
            if (insn_last) begin
              state      <= ST_IDLE;
              insn_valid <= 1'b0;
              insn_last  <= 1'b0;
            end else begin
              hw_q      <= next_sel.hw;
              insn_last <= !after_sel.found;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_insn_encoder.sv
// Directed, table-driven bench for insn_encoder plus hand-written stall,
// reset and counter-wrap sequences.
module tb_insn_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_rd, cmd_rn, cmd_rm;
  logic [63:0] cmd_imm;
  logic        insn_ready;

  logic        cmd_ready, insn_valid, insn_last, err;
  logic [31:0] insn_data;
  logic [15:0] insn_count;

  logic        cmd_ready_4, insn_valid_4, insn_last_4, err_4;
  logic [31:0] insn_data_4;
  logic [3:0]  insn_count_4;

  always #5 clk = ~clk;

  insn_encoder #(.COUNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_imm(cmd_imm), .insn_valid(insn_valid), .insn_ready(insn_ready),
    .insn_data(insn_data), .insn_last(insn_last), .err(err),
    .insn_count(insn_count)
  );

  insn_encoder #(.COUNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_4),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_imm(cmd_imm), .insn_valid(insn_valid_4), .insn_ready(insn_ready),
    .insn_data(insn_data_4), .insn_last(insn_last_4), .err(err_4),
    .insn_count(insn_count_4)
  );

  typedef struct {
    logic [2:0]       op;
    logic [4:0]       rd, rn, rm;
    logic [63:0]      imm;
    bit               bad;
    int               n;
    logic [3:0][31:0] w;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt;
  vec_t        vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                              input logic [4:0] rm, input logic [63:0] imm, input bit bad,
                              input int n, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
    vec_t v;
    v.op = op; v.rd = rd; v.rn = rn; v.rm = rm; v.imm = imm; v.bad = bad; v.n = n;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    return v;
  endfunction

  // Present a command at a falling edge; returns on the falling edge after acceptance.
  task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input logic [63:0] imm);
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready_before_send", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_imm = imm;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0;
    cmd_imm = '0; insn_ready = 1'b1;

    vecs[0]  = mk(3'd0, 5'd3,  5'd0, 5'd0, 64'h0001_0000_0000_BEEF, 0, 2,
                  32'hD297DDE3, 32'hF2E00023, 32'h0, 32'h0);
    vecs[1]  = mk(3'd0, 5'd0,  5'd0, 5'd0, 64'h0, 0, 1, 32'hD2800000, 32'h0, 32'h0, 32'h0);
    vecs[2]  = mk(3'd0, 5'd31, 5'd0, 5'd0, 64'h1234_5678_9ABC_DEF0, 0, 4,
                  32'hD29BDE1F, 32'hF2B3579F, 32'hF2CACF1F, 32'hF2E2469F);
    vecs[3]  = mk(3'd0, 5'd5,  5'd0, 5'd0, 64'h0000_FFFF_0000_0000, 0, 2,
                  32'hD2800005, 32'hF2DFFFE5, 32'h0, 32'h0);
    vecs[4]  = mk(3'd1, 5'd1,  5'd2, 5'd0, 64'h5000, 0, 1, 32'h91401441, 32'h0, 32'h0, 32'h0);
    vecs[5]  = mk(3'd1, 5'd0,  5'd0, 5'd0, 64'd4095, 0, 1, 32'h913FFC00, 32'h0, 32'h0, 32'h0);
    vecs[6]  = mk(3'd2, 5'd3,  5'd4, 5'd0, 64'hFF_F000, 0, 1, 32'hD17FFC83, 32'h0, 32'h0, 32'h0);
    vecs[7]  = mk(3'd2, 5'd1,  5'd2, 5'd0, 64'h1001, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[8]  = mk(3'd1, 5'd1,  5'd2, 5'd0, 64'h100_0000, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[9]  = mk(3'd3, 5'd0,  5'd4, 5'd5, 64'h0, 0, 1, 32'hEB05009F, 32'h0, 32'h0, 32'h0);
    vecs[10] = mk(3'd4, 5'd7,  5'd0, 5'd0, -64'sd2, 0, 1, 32'hB4FFFFC7, 32'h0, 32'h0, 32'h0);
    vecs[11] = mk(3'd4, 5'd7,  5'd0, 5'd0, 64'h4_0000, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[12] = mk(3'd4, 5'd0,  5'd0, 5'd0, 64'h3_FFFF, 0, 1, 32'hB47FFFE0, 32'h0, 32'h0, 32'h0);
    vecs[13] = mk(3'd4, 5'd1,  5'd0, 5'd0, -64'sh4_0000, 0, 1, 32'hB4800001, 32'h0, 32'h0, 32'h0);
    vecs[14] = mk(3'd5, 5'd1,  5'd2, 5'd3, 64'h0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[15] = mk(3'd7, 5'd1,  5'd2, 5'd3, 64'h0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_cmd_ready",  cmd_ready,  1);
    check("reset_insn_valid", insn_valid, 0);
    check("reset_insn_last",  insn_last,  0);
    check("reset_insn_data",  insn_data,  0);
    check("reset_err",        err,        0);
    check("reset_count",      insn_count, 0);
    exp_cnt = '0;

    for (int i = 0; i < 16; i++) begin
      send(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm);
      if (vecs[i].bad) begin
        check($sformatf("v%0d_err", i), err, 1);
        check($sformatf("v%0d_no_word", i), insn_valid, 0);
        @(negedge clk);
        check($sformatf("v%0d_err_pulse", i), err, 0);
      end else begin
        for (int w = 0; w < vecs[i].n; w++) begin
          check($sformatf("v%0d_w%0d_valid", i, w), insn_valid, 1);
          check($sformatf("v%0d_w%0d_data", i, w), insn_data, vecs[i].w[w]);
          check($sformatf("v%0d_w%0d_last", i, w), insn_last, (w == vecs[i].n - 1) ? 1 : 0);
          @(negedge clk);
        end
        exp_cnt = exp_cnt + 16'(vecs[i].n);
        check($sformatf("v%0d_idle_valid", i), insn_valid, 0);
        check($sformatf("v%0d_ready_back", i), cmd_ready, 1);
      end
      check($sformatf("v%0d_count", i), insn_count, exp_cnt);
    end

    // CMP held off for three cycles; a competing command must be ignored.
    insn_ready = 1'b0;
    send(3'd3, 5'd0, 5'd4, 5'd5, 64'h0);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_rn = 5'd1; cmd_rm = 5'd2;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("stall%0d_data", c), insn_data, 32'hEB05009F);
      check($sformatf("stall%0d_valid", c), insn_valid, 1);
      check($sformatf("stall%0d_last", c), insn_last, 1);
      check($sformatf("stall%0d_busy", c), cmd_ready, 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    insn_ready = 1'b1;
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    check("stall_done_valid", insn_valid, 0);
    check("stall_done_count", insn_count, exp_cnt);

    // Reset while the second word of a three-word MOVI is stalled.
    send(3'd0, 5'd0, 5'd0, 5'd0, 64'h0000_0001_0002_0003);
    check("rmid_w0", insn_data, 32'hD2800060);
    @(negedge clk);
    insn_ready = 1'b0;
    check("rmid_w1", insn_data, 32'hF2A00040);
    @(negedge clk);
    check("rmid_w1_held", insn_data, 32'hF2A00040);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    insn_ready = 1'b1;
    check("rmid_valid",  insn_valid,   0);
    check("rmid_ready",  cmd_ready,    1);
    check("rmid_count",  insn_count,   0);
    check("rmid_data",   insn_data,    0);
    check("rmid_valid4", insn_valid_4, 0);
    check("rmid_ready4", cmd_ready_4,  1);
    @(negedge clk);
    check("rmid_idle", insn_valid, 0);

    // Seventeen single-word commands wrap the 4-bit counter to 1.
    for (int k = 0; k < 17; k++) begin
      send(3'd3, 5'd0, 5'(k), 5'd1, 64'h0);
      @(negedge clk);
    end
    check("wrap_count4", insn_count_4, 4'd1);
    check("wrap_count16", insn_count, 16'd17);
    check("wrap_err4", err_4, 0);
    check("wrap_last4", insn_last_4, 0);
    check("wrap_data4", insn_data_4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
